// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file with byte-lane strobes and optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we_a,
  input  logic [ADDR_W-1:0]   wa_a,
  input  logic [DATA_W-1:0]   wd_a,
  input  logic [DATA_W/8-1:0] wstrb_a,
  input  logic                we_b,
  input  logic [ADDR_W-1:0]   wa_b,
  input  logic [DATA_W-1:0]   wd_b,
  input  logic [DATA_W/8-1:0] wstrb_b,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2
);

  localparam int NumLanes = DATA_W / 8;
  localparam int Depth    = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [Depth];

  logic wrA;
  logic wrB;

  // Writes aimed at a hard-wired zero register are dropped here.
  assign wrA = we_a && !((ZERO_REG != 0) && (wa_a == '0));
  assign wrB = we_b && !((ZERO_REG != 0) && (wa_b == '0));

  // Port B is applied after port A so it wins on shared lanes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int l = 0; l < NumLanes; l++) begin
        if (wrA && wstrb_a[l]) begin
          regs[wa_a][l*8 +: 8] <= wd_a[l*8 +: 8];
        end
        if (wrB && wstrb_b[l]) begin
          regs[wa_b][l*8 +: 8] <= wd_b[l*8 +: 8];
        end
      end
    end
  end

  logic [ADDR_W-1:0] rAddr [2];
  logic [DATA_W-1:0] rData [2];

  assign rAddr[0] = ra1;
  assign rAddr[1] = ra2;
  assign rd1      = rData[0];
  assign rd2      = rData[1];

  for (genvar p = 0; p < 2; p++) begin : gRead
    always_comb begin
      rData[p] = regs[rAddr[p]];
`ifdef REGFILE_BYPASS_EN
      for (int l = 0; l < NumLanes; l++) begin
        if (reset_n && wrA && (wa_a == rAddr[p]) && wstrb_a[l]) begin
          rData[p][l*8 +: 8] = wd_a[l*8 +: 8];
        end
        if (reset_n && wrB && (wa_b == rAddr[p]) && wstrb_b[l]) begin
          rData[p][l*8 +: 8] = wd_b[l*8 +: 8];
        end
      end
`endif
      if ((ZERO_REG != 0) && (rAddr[p] == '0)) begin
        rData[p] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: one instance with the zero register,
// one without, sharing all inputs.
module tb_regfile_2w2r;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we_a, we_b;
  logic [4:0]  wa_a, wa_b, ra1, ra2;
  logic [31:0] wd_a, wd_b;
  logic [3:0]  wstrb_a, wstrb_b;
  logic [31:0] rd1, rd2, rd1Nz, rd2Nz;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .wstrb_a(wstrb_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .wstrb_b(wstrb_b),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutNz (
    .clk(clk), .reset_n(reset_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .wstrb_a(wstrb_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .wstrb_b(wstrb_b),
    .ra1(ra1), .ra2(ra2), .rd1(rd1Nz), .rd2(rd2Nz)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setA(input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    we_a = we; wa_a = a; wd_a = d; wstrb_a = s;
  endtask

  task automatic setB(input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    we_b = we; wa_b = a; wd_b = d; wstrb_b = s;
  endtask

  task automatic idle();
    setA(1'b0, 5'd0, 32'h0, 4'h0);
    setB(1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  logic [31:0] expPre;

  initial begin
    reset_n = 1'b0;
    idle();
    ra1 = 5'd0;
    ra2 = 5'd0;
    tick();
    tick();
    reset_n = 1'b1;

    ra1 = 5'd3; ra2 = 5'd31; #1;
    check("rst_r3", rd1, 32'h0);
    check("rst_r31", rd2, 32'h0);
    check("rst_r3_nz", rd1Nz, 32'h0);

    // preload then reset with a colliding write
    setA(1'b1, 5'd3, 32'h12345678, 4'hF);
    tick();
    idle();
    #1;
    check("preload_r3", rd1, 32'h12345678);
    reset_n = 1'b0;
    setA(1'b1, 5'd3, 32'hFFFFFFFF, 4'hF);
    #1;
    check("rst_nofwd", rd1, 32'h12345678);
    tick();
    reset_n = 1'b1;
    idle();
    #1;
    check("rst_clear", rd1, 32'h0);
    check("rst_clear_nz", rd1Nz, 32'h0);

    // basic dual write
    setA(1'b1, 5'd1, 32'hdeadbeef, 4'hF);
    setB(1'b1, 5'd10, 32'hbeefdead, 4'hF);
    tick();
    idle();
    ra1 = 5'd1; ra2 = 5'd10; #1;
    check("basic_a", rd1, 32'hdeadbeef);
    check("basic_b", rd2, 32'hbeefdead);

    // byte strobes
    setA(1'b1, 5'd5, 32'hAAAAAAAA, 4'hF);
    tick();
    setA(1'b1, 5'd5, 32'h11223344, 4'b0101);
    tick();
    idle();
    ra1 = 5'd5; #1;
    check("strobe", rd1, 32'hAA22AA44);

    // zero strobes with enable: no effect
    setA(1'b1, 5'd1, 32'h00000000, 4'h0);
    setB(1'b1, 5'd1, 32'h00000000, 4'h0);
    tick();
    idle();
    ra1 = 5'd1; #1;
    check("nostrobe", rd1, 32'hdeadbeef);

    // collision: B wins on its lanes
    setA(1'b1, 5'd7, 32'h11111111, 4'hF);
    setB(1'b1, 5'd7, 32'h22222222, 4'b0011);
    tick();
    idle();
    ra1 = 5'd7; ra2 = 5'd7; #1;
    check("collide", rd1, 32'h11112222);
    check("same_addr", rd2, 32'h11112222);
    check("collide_nz", rd1Nz, 32'h11112222);

    // collision with a lane nobody strobes
    setA(1'b1, 5'd8, 32'hAAAAAAAA, 4'b1100);
    setB(1'b1, 5'd8, 32'hBBBBBBBB, 4'b0001);
    tick();
    idle();
    ra2 = 5'd8; #1;
    check("collide_hold", rd2, 32'hAAAA00BB);

    // zero register
    setA(1'b1, 5'd0, 32'h12345678, 4'hF);
    setB(1'b1, 5'd0, 32'hCAFEF00D, 4'hF);
    tick();
    idle();
    ra1 = 5'd0; ra2 = 5'd0; #1;
    check("zero_r0", rd1, 32'h0);
    check("zero_r0_rd2", rd2, 32'h0);
    check("nz_r0", rd1Nz, 32'hCAFEF00D);

    // write-to-read in the same cycle
    setA(1'b1, 5'd4, 32'h55AA55AA, 4'hF);
    ra1 = 5'd4; #1;
`ifdef REGFILE_BYPASS_EN
    expPre = 32'h55AA55AA;
`else
    expPre = 32'h0;
`endif
    check("byp_pre", rd1, expPre);
    tick();
    idle();
    #1;
    check("byp_post", rd1, 32'h55AA55AA);

    // same-cycle collision seen through the read port
    setA(1'b1, 5'd9, 32'h11111111, 4'b0011);
    setB(1'b1, 5'd9, 32'h22222222, 4'b0110);
    ra2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    expPre = 32'h00222211;
`else
    expPre = 32'h0;
`endif
    check("byp_coll_pre", rd2, expPre);
    tick();
    idle();
    #1;
    check("byp_coll_post", rd2, 32'h00222211);

    // same-cycle write to address 0
    setA(1'b1, 5'd0, 32'h0BADF00D, 4'hF);
    ra1 = 5'd0; #1;
`ifdef REGFILE_BYPASS_EN
    expPre = 32'h0BADF00D;
`else
    expPre = 32'hCAFEF00D;
`endif
    check("byp_r0_zero", rd1, 32'h0);
    check("byp_r0_nz", rd1Nz, expPre);
    tick();
    idle();
    #1;
    check("r0_post", rd1, 32'h0);
    check("r0_post_nz", rd1Nz, 32'h0BADF00D);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised successor to the single-write register file: 2 async read ports, 2 sync write ports, byte-lane write strobes, optional hard-wired zero register, synchronous clear.
- Sits in the datapath between decode (read addresses) and writeback (write ports).
- Two write ports let a dual-issue or load/ALU writeback retire both results in one cycle.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 register 0 is ordinary storage.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- we_a  in  1  write enable, port A
- wa_a  in  ADDR_W  write address, port A
- wd_a  in  DATA_W  write data, port A
- wstrb_a  in  DATA_W/8  byte-lane strobes, port A
- we_b  in  1  write enable, port B
- wa_b  in  ADDR_W  write address, port B
- wd_b  in  DATA_W  write data, port B
- wstrb_b  in  DATA_W/8  byte-lane strobes, port B
- ra1  in  ADDR_W  read address 1
- ra2  in  ADDR_W  read address 2
- rd1  out  DATA_W  read data 1
- rd2  out  DATA_W  read data 2

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n). Polarity and synchronicity are fixed.
- Reset: on any rising edge with reset_n=0, every register becomes 0 and both write ports are ignored that cycle. rd1/rd2 therefore read 0 from the cycle after reset onward.
- Reset mid-operation: a write presented in the same cycle as reset_n=0 is lost, not deferred.
- Write:
  - On a rising edge with reset_n=1 and we_x=1, byte lane i of reg[wa_x] takes wd_x[8i+7:8i] only where wstrb_x[i]=1.
  - Other lanes hold their value.
  - Latency 1 cycle; the new value is visible on reads after the edge.
- we_x=1 with wstrb_x=0 is legal and has no effect.
- Write collision (wa_a==wa_b, both enabled): resolved per lane.
  - Port B wins on lanes where wstrb_b=1.
  - Port A lands on lanes where only wstrb_a=1.
  - Lanes with neither strobe hold.
- Read: combinational. rd1=reg[ra1] and rd2=reg[ra2] from current stored state, with no clock dependency.
- Same-cycle write-to-read with REGFILE_BYPASS_EN undefined: returns the old value.
- ra1==ra2 is legal; both outputs carry the same value.
- ZERO_REG=1:
  - Writes to address 0 are discarded on both ports, including during a collision.
  - rd1/rd2 are 0 whenever their address is 0, independent of storage and bypass.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range case exists.
- No X propagation from unused lanes: storage is fully initialised by reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If a read address equals an enabled write address in the same cycle (and is not a ZERO_REG-protected address 0), each strobed lane of rdN shows the incoming write data combinationally.
  - Collision priority is the same as for storage: B over A, per lane.
  - Unstrobed lanes show the stored value.
  - Forwarding is suppressed while reset_n=0; rdN shows the stored value.
- Undefined: no forwarding logic. Reads reflect stored state only; the new value appears the cycle after the edge.

Test Plan:
- Reset clear: preload reg[3]=32'h12345678, hold reset_n=0 one edge -> rd1(ra1=3)=0. A simultaneous we_a write to reg[3] of 32'hFFFFFFFF is also lost -> still 0.
- Basic write/read: we_a=1, wa_a=1, wd_a=32'hdeadbeef, wstrb_a=4'hF; next cycle ra1=1 -> rd1=32'hdeadbeef. With wa_b=10, wd_b=32'hbeefdead in the same cycle, ra2=10 -> rd2=32'hbeefdead.
- Byte strobes: reg[5]=32'hAAAAAAAA; write wd_a=32'h11223344, wstrb_a=4'b0101 -> reg[5]=32'hAA22AA44.
- Collision: reg[7]=0; wa_a=wa_b=7, wd_a=32'h11111111 with wstrb_a=4'hF, wd_b=32'h22222222 with wstrb_b=4'b0011 -> reg[7]=32'h11112222.
- Zero register (ZERO_REG=1): write 32'hCAFEF00D to addr 0 on both ports -> rd1(ra1=0)=0. Repeat with ZERO_REG=0 -> 32'hCAFEF00D (port B data).
- Bypass: reg[4]=32'h0, same cycle we_a=1, wa_a=4, wd_a=32'h55AA55AA, ra1=4.
  - REGFILE_BYPASS_EN defined -> rd1=32'h55AA55AA before the edge.
  - Undefined -> rd1=0 before the edge and 32'h55AA55AA after.
